// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_defs_pkg
// Brief    : Register-file geometry and the writeback request bundle shared
//            by the pipeline WB stage and the regfile write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_defs_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] wa;
        logic [REG_DW-1:0] wd;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Brief    : Circular buffer of pending register writes with a per-entry
//            valid bit, squash-by-address and full entry visibility.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [AW-1:0]            push_wa,
    input  logic [DW-1:0]            push_wd,
    input  logic                     pop,
    input  logic                     squash_en,
    input  logic [AW-1:0]            squash_wa,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [AW-1:0]            head_wa,
    output logic [DW-1:0]            head_wd,
    output logic [$clog2(DEPTH)-1:0] wr_idx,
    output logic [DEPTH-1:0]         ent_valid,
    output logic [AW-1:0]            ent_wa [DEPTH],
    output logic [DW-1:0]            ent_wd [DEPTH]
);

    localparam int c_IW = $clog2(DEPTH);
    localparam int c_PW = c_IW + 1;

    localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);

    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]    r_wa [DEPTH];
    logic [DW-1:0]    r_wd [DEPTH];

    logic [c_IW-1:0]  w_wr_idx;
    logic [c_IW-1:0]  w_rd_idx;

    assign w_wr_idx = r_wr_ptr[c_IW-1:0];
    assign w_rd_idx = r_rd_ptr[c_IW-1:0];

    // Extra pointer MSB separates the full and empty cases of equal indices.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_PW-1] != r_rd_ptr[c_PW-1]) && (w_wr_idx == w_rd_idx);
    assign count = r_wr_ptr - r_rd_ptr;

    assign head_valid = !empty && r_valid[w_rd_idx];
    assign head_wa    = r_wa[w_rd_idx];
    assign head_wd    = r_wd[w_rd_idx];

    assign wr_idx    = w_wr_idx;
    assign ent_valid = r_valid;
    assign ent_wa    = r_wa;
    assign ent_wd    = r_wd;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_wa[i] <= '0;
                r_wd[i] <= '0;
            end
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end

            for (int i = 0; i < DEPTH; i++) begin
                if (squash_en && r_valid[i] && (r_wa[i] == squash_wa)) begin
                    r_valid[i] <= 1'b0;
                end
            end

            if (pop) begin
                r_valid[w_rd_idx] <= 1'b0;
            end

            // Last assignment wins: a fresh push is never squashed by the
            // pipeline write of the same cycle, and may reuse the popped slot.
            if (push) begin
                r_valid[w_wr_idx] <= 1'b1;
                r_wa[w_wr_idx]    <= push_wa;
                r_wd[w_wr_idx]    <= push_wd;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_arbiter
// Brief    : Merges the pipeline WB stage and a buffered long-latency source
//            onto the single regfile write port, with forwarding and stall.
// Revision : 1.0 - initial release
// ============================================================================
module wb_write_arbiter
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wb_we,
    input  logic [AW-1:0]          wb_wa,
    input  logic [DW-1:0]          wb_wd,
    input  logic                   sec_valid,
    output logic                   sec_ready,
    input  logic [AW-1:0]          sec_wa,
    input  logic [DW-1:0]          sec_wd,
    output logic                   rf_we,
    output logic [AW-1:0]          rf_wa,
    output logic [DW-1:0]          rf_wd,
    input  logic [AW-1:0]          fwd_ra1,
    input  logic [AW-1:0]          fwd_ra2,
    output logic                   fwd_hit1,
    output logic                   fwd_hit2,
    output logic [DW-1:0]          fwd_d1,
    output logic [DW-1:0]          fwd_d2,
    output logic                   wb_stall_req,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int c_IW = $clog2(DEPTH);

    localparam logic [AW-1:0] c_ZERO = AW'(REG_ZERO);

    logic                 w_wb_act;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_head_valid;
    logic [AW-1:0]        w_head_wa;
    logic [DW-1:0]        w_head_wd;
    logic [c_IW-1:0]      w_wr_idx;
    logic [DEPTH-1:0]     w_ent_valid;
    logic [AW-1:0]        w_ent_wa [DEPTH];
    logic [DW-1:0]        w_ent_wd [DEPTH];

    // A write to $0 is architecturally a no-op, so it never claims the port.
    assign w_wb_act = wb_we && (wb_wa != c_ZERO);

    // Any idle slot retires the head; a squashed head simply leaves rf_we low.
    assign w_pop = !w_wb_act && !w_empty;

    assign sec_ready    = !w_full || w_pop;
    assign w_push       = sec_valid && sec_ready && (sec_wa != c_ZERO);
    assign wb_stall_req = w_full && w_wb_act;

    wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (w_push),
        .push_wa    (sec_wa),
        .push_wd    (sec_wd),
        .pop        (w_pop),
        .squash_en  (w_wb_act),
        .squash_wa  (wb_wa),
        .empty      (w_empty),
        .full       (w_full),
        .count      (fifo_count),
        .head_valid (w_head_valid),
        .head_wa    (w_head_wa),
        .head_wd    (w_head_wd),
        .wr_idx     (w_wr_idx),
        .ent_valid  (w_ent_valid),
        .ent_wa     (w_ent_wa),
        .ent_wd     (w_ent_wd)
    );

    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (w_wb_act) begin
            rf_we = 1'b1;
            rf_wa = wb_wa;
            rf_wd = wb_wd;
        end else if (w_head_valid) begin
            rf_we = 1'b1;
            rf_wa = w_head_wa;
            rf_wd = w_head_wd;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_fwd
        logic [AW-1:0]   w_ra;
        logic            w_hit;
        logic [DW-1:0]   w_d;
        logic [c_IW-1:0] w_slot;

        assign w_ra = (p == 0) ? fwd_ra1 : fwd_ra2;

        // Walk slots oldest to youngest so the youngest match overwrites.
        always_comb begin
            w_hit  = 1'b0;
            w_d    = '0;
            w_slot = '0;
            for (int age = DEPTH - 1; age >= 0; age--) begin
                w_slot = w_wr_idx - c_IW'(age + 1);
                if ((w_ra != c_ZERO) && w_ent_valid[w_slot] && (w_ent_wa[w_slot] == w_ra)) begin
                    w_hit = 1'b1;
                    w_d   = w_ent_wd[w_slot];
                end
            end
        end
    end

    assign fwd_hit1 = g_fwd[0].w_hit;
    assign fwd_d1   = g_fwd[0].w_d;
    assign fwd_hit2 = g_fwd[1].w_hit;
    assign fwd_d2   = g_fwd[1].w_d;

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_write_arbiter
// Brief    : Scoreboard bench for the regfile write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_write_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   wb_we;
    logic [AW-1:0]          wb_wa;
    logic [DW-1:0]          wb_wd;
    logic                   sec_valid;
    logic                   sec_ready;
    logic [AW-1:0]          sec_wa;
    logic [DW-1:0]          sec_wd;
    logic                   rf_we;
    logic [AW-1:0]          rf_wa;
    logic [DW-1:0]          rf_wd;
    logic [AW-1:0]          fwd_ra1;
    logic [AW-1:0]          fwd_ra2;
    logic                   fwd_hit1;
    logic                   fwd_hit2;
    logic [DW-1:0]          fwd_d1;
    logic [DW-1:0]          fwd_d2;
    logic                   wb_stall_req;
    logic [$clog2(DEPTH):0] fifo_count;

    typedef struct {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wr_t;

    wr_t           exp_q [$];
    wr_t           got;
    logic [DW-1:0] rf_mem [32];
    int            n_checks = 0;
    int            n_pass   = 0;

    wb_write_arbiter #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .wb_we        (wb_we),
        .wb_wa        (wb_wa),
        .wb_wd        (wb_wd),
        .sec_valid    (sec_valid),
        .sec_ready    (sec_ready),
        .sec_wa       (sec_wa),
        .sec_wd       (sec_wd),
        .rf_we        (rf_we),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd),
        .fwd_ra1      (fwd_ra1),
        .fwd_ra2      (fwd_ra2),
        .fwd_hit1     (fwd_hit1),
        .fwd_hit2     (fwd_hit2),
        .fwd_d1       (fwd_d1),
        .fwd_d2       (fwd_d2),
        .wb_stall_req (wb_stall_req),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    // Write-port monitor: pipeline writes must pass straight through; every
    // other write must be the oldest outstanding secondary result.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (wb_we && (wb_wa != '0)) begin
                n_checks++;
                if (rf_we !== 1'b1 || rf_wa !== wb_wa || rf_wd !== wb_wd)
                    $display("FAIL wb_passthrough: got we=%0b wa=%0d wd=%h, expected we=1 wa=%0d wd=%h", rf_we, rf_wa, rf_wd, wb_wa, wb_wd);
                else n_pass++;
            end else if (rf_we === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_write: got wa=%0d wd=%h, expected no write", rf_wa, rf_wd);
                end else begin
                    got = exp_q.pop_front();
                    if (rf_wa !== got.wa || rf_wd !== got.wd)
                        $display("FAIL drain_order: got wa=%0d wd=%h, expected wa=%0d wd=%h", rf_wa, rf_wd, got.wa, got.wd);
                    else n_pass++;
                end
            end
        end
        if (rf_we === 1'b1) rf_mem[rf_wa] <= rf_wd;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        fwd_ra1 = 5'd3;
        fwd_ra2 = 5'd7;
        #2;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we: got %0b expected 0", rf_we); else n_pass++;
        n_checks++; if (sec_ready !== 1'b1) $display("FAIL reset_sec_ready: got %0b expected 1", sec_ready); else n_pass++;
        n_checks++; if (wb_stall_req !== 1'b0) $display("FAIL reset_stall: got %0b expected 0", wb_stall_req); else n_pass++;
        n_checks++; if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0) $display("FAIL reset_fwd_hit: got %0b%0b expected 00", fwd_hit1, fwd_hit2); else n_pass++;
        n_checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", fifo_count); else n_pass++;
        @(posedge clk);
        #1 resetn = 1'b1;
        fwd_ra1 = '0;
        fwd_ra2 = '0;
    endtask

    task automatic test_idle_drain();
        sec_valid = 1'b1; sec_wa = 5'd5; sec_wd = 32'h1234;
        @(negedge clk);
        n_checks++; if (sec_ready !== 1'b1) $display("FAIL idle_ready: got %0b expected 1", sec_ready); else n_pass++;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL idle_no_bypass: got rf_we=%0b expected 0", rf_we); else n_pass++;
        tick();
        exp_q.push_back(wr_t'{5'd5, 32'h1234});
        sec_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'h1234) $display("FAIL idle_emit: got we=%0b wa=%0d wd=%h expected we=1 wa=5 wd=1234", rf_we, rf_wa, rf_wd); else n_pass++;
        n_checks++; if (fifo_count !== 3'd1) $display("FAIL idle_count1: got %0d expected 1", fifo_count); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) $display("FAIL idle_done: got we=%0b count=%0d expected we=0 count=0", rf_we, fifo_count); else n_pass++;
        tick();
    endtask

    task automatic test_priority_full();
        for (int i = 0; i < 4; i++) begin
            wb_we = 1'b1; wb_wa = 5'(20 + i); wb_wd = 32'hB000 + i;
            sec_valid = 1'b1; sec_wa = 5'(1 + i); sec_wd = 32'h100 + i;
            @(negedge clk);
            n_checks++; if (sec_ready !== 1'b1) $display("FAIL pf_ready_%0d: got %0b expected 1", i, sec_ready); else n_pass++;
            tick();
            exp_q.push_back(wr_t'{5'(1 + i), 32'h100 + i});
        end
        wb_wa = 5'd24; wb_wd = 32'hB004; sec_wa = 5'd9; sec_wd = 32'h900;
        @(negedge clk);
        n_checks++; if (fifo_count !== 3'd4) $display("FAIL pf_full_count: got %0d expected 4", fifo_count); else n_pass++;
        n_checks++; if (wb_stall_req !== 1'b1) $display("FAIL pf_stall: got %0b expected 1", wb_stall_req); else n_pass++;
        n_checks++; if (sec_ready !== 1'b0) $display("FAIL pf_full_ready: got %0b expected 0", sec_ready); else n_pass++;
        tick();
        wb_we = 1'b0; sec_wa = 5'd6; sec_wd = 32'h600;
        @(negedge clk);
        n_checks++; if (sec_ready !== 1'b1 || wb_stall_req !== 1'b0) $display("FAIL pf_full_pop_ready: got ready=%0b stall=%0b expected ready=1 stall=0", sec_ready, wb_stall_req); else n_pass++;
        tick();
        exp_q.push_back(wr_t'{5'd6, 32'h600});
        sec_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_checks++; if (fifo_count !== 3'(5 - k)) $display("FAIL pf_drain_count_%0d: got %0d expected %0d", k, fifo_count, 5 - k); else n_pass++;
            n_checks++; if (rf_we !== (k < 5)) $display("FAIL pf_drain_we_%0d: got %0b expected %0b", k, rf_we, k < 5); else n_pass++;
            tick();
        end
    endtask

    task automatic test_waw_squash();
        sec_valid = 1'b1; sec_wa = 5'd7; sec_wd = 32'hAAAA;
        tick();
        sec_valid = 1'b0;
        wb_we = 1'b1; wb_wa = 5'd7; wb_wd = 32'hBBBB; fwd_ra1 = 5'd7;
        @(negedge clk);
        n_checks++; if (fwd_hit1 !== 1'b1 || fwd_d1 !== 32'hAAAA) $display("FAIL waw_fwd_before: got hit=%0b d=%h expected hit=1 d=aaaa", fwd_hit1, fwd_d1); else n_pass++;
        tick();
        wb_we = 1'b0;
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b0) $display("FAIL waw_squash_we: got %0b expected 0", rf_we); else n_pass++;
        n_checks++; if (fifo_count !== 3'd1 || fwd_hit1 !== 1'b0) $display("FAIL waw_squashed_entry: got count=%0d hit=%0b expected count=1 hit=0", fifo_count, fwd_hit1); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (fifo_count !== 3'd0) $display("FAIL waw_count: got %0d expected 0", fifo_count); else n_pass++;
        n_checks++; if (rf_mem[7] !== 32'hBBBB) $display("FAIL waw_r7: got %h expected bbbb", rf_mem[7]); else n_pass++;
        tick();
        fwd_ra1 = '0;
        wb_we = 1'b1; wb_wa = 5'd8; wb_wd = 32'hC1;
        sec_valid = 1'b1; sec_wa = 5'd8; sec_wd = 32'hC2;
        tick();
        exp_q.push_back(wr_t'{5'd8, 32'hC2});
        wb_we = 1'b0; sec_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd8) $display("FAIL waw_same_cycle_push: got we=%0b wa=%0d expected we=1 wa=8", rf_we, rf_wa); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (rf_mem[8] !== 32'hC2) $display("FAIL waw_r8: got %h expected c2", rf_mem[8]); else n_pass++;
        tick();
    endtask

    task automatic test_forwarding();
        wb_we = 1'b1; wb_wa = 5'd30; wb_wd = 32'hF0;
        sec_valid = 1'b1; sec_wa = 5'd3; sec_wd = 32'h11;
        fwd_ra1 = 5'd3; fwd_ra2 = 5'd0;
        @(negedge clk);
        n_checks++; if (fwd_hit1 !== 1'b0) $display("FAIL fwd_push_invisible: got hit=%0b expected 0", fwd_hit1); else n_pass++;
        tick();
        exp_q.push_back(wr_t'{5'd3, 32'h11});
        sec_wd = 32'h22;
        @(negedge clk);
        n_checks++; if (fwd_hit1 !== 1'b1 || fwd_d1 !== 32'h11) $display("FAIL fwd_first: got hit=%0b d=%h expected hit=1 d=11", fwd_hit1, fwd_d1); else n_pass++;
        tick();
        exp_q.push_back(wr_t'{5'd3, 32'h22});
        sec_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (fwd_hit1 !== 1'b1 || fwd_d1 !== 32'h22) $display("FAIL fwd_youngest: got hit=%0b d=%h expected hit=1 d=22", fwd_hit1, fwd_d1); else n_pass++;
        n_checks++; if (fwd_hit2 !== 1'b0) $display("FAIL fwd_r0: got hit=%0b expected 0", fwd_hit2); else n_pass++;
        fwd_ra2 = 5'd4;
        #1;
        n_checks++; if (fwd_hit2 !== 1'b0) $display("FAIL fwd_miss: got hit=%0b expected 0", fwd_hit2); else n_pass++;
        fwd_ra2 = 5'd3;
        #1;
        n_checks++; if (fwd_hit2 !== 1'b1 || fwd_d2 !== 32'h22) $display("FAIL fwd_port2: got hit=%0b d=%h expected hit=1 d=22", fwd_hit2, fwd_d2); else n_pass++;
        tick();
        wb_we = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_checks++; if (fifo_count !== 3'd0 || fwd_hit1 !== 1'b0) $display("FAIL fwd_drained: got count=%0d hit=%0b expected count=0 hit=0", fifo_count, fwd_hit1); else n_pass++;
        fwd_ra1 = '0; fwd_ra2 = '0;
        tick();
    endtask

    task automatic test_zero_filter();
        sec_valid = 1'b1; sec_wa = 5'd0; sec_wd = 32'hFFFF;
        @(negedge clk);
        n_checks++; if (sec_ready !== 1'b1) $display("FAIL zero_ack: got %0b expected 1", sec_ready); else n_pass++;
        tick();
        sec_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (fifo_count !== 3'd0 || rf_we !== 1'b0) $display("FAIL zero_dropped: got count=%0d we=%0b expected count=0 we=0", fifo_count, rf_we); else n_pass++;
        tick();
        wb_we = 1'b1; wb_wa = 5'd13; wb_wd = 32'hD0;
        sec_valid = 1'b1; sec_wa = 5'd12; sec_wd = 32'h55;
        tick();
        exp_q.push_back(wr_t'{5'd12, 32'h55});
        sec_valid = 1'b0;
        wb_wa = 5'd0; wb_wd = 32'hDEAD;
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd12) $display("FAIL zero_wb_idle: got we=%0b wa=%0d expected we=1 wa=12", rf_we, rf_wa); else n_pass++;
        tick();
        wb_we = 1'b0;
        @(negedge clk);
        n_checks++; if (fifo_count !== 3'd0) $display("FAIL zero_count: got %0d expected 0", fifo_count); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) begin
            wb_we = 1'b1; wb_wa = 5'(25 + i); wb_wd = 32'hA0 + i;
            sec_valid = 1'b1; sec_wa = 5'(14 + i); sec_wd = 32'hE0 + i;
            tick();
            exp_q.push_back(wr_t'{5'(14 + i), 32'hE0 + i});
        end
        wb_we = 1'b0; sec_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (fifo_count !== 3'd3) $display("FAIL rst_pre_count: got %0d expected 3", fifo_count); else n_pass++;
        tick();
        #2;
        exp_q.delete();
        resetn = 1'b0;
        #1;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL rst_async_we: got %0b expected 0", rf_we); else n_pass++;
        n_checks++; if (fifo_count !== 3'd0 || sec_ready !== 1'b1) $display("FAIL rst_async_state: got count=%0d ready=%0b expected count=0 ready=1", fifo_count, sec_ready); else n_pass++;
        @(posedge clk);
        #1 resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) $display("FAIL rst_after_%0d: got we=%0b count=%0d expected we=0 count=0", k, rf_we, fifo_count); else n_pass++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
        sec_valid = 1'b0; sec_wa = '0; sec_wd = '0;
        fwd_ra1 = '0; fwd_ra2 = '0;
        for (int r = 0; r < 32; r++) rf_mem[r] = '0;
        test_reset();
        test_idle_drain();
        test_priority_full();
        test_waw_squash();
        test_forwarding();
        test_zero_filter();
        test_reset_mid_drain();
        n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d pending expected 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Write-side front end for the 32x32 register file.
- Merges two writeback sources into the file's single write port (we3/wa3/wd3):
  - the in-order pipeline WB stage, which has absolute priority and no backpressure;
  - a long-latency secondary source (load-miss return, mul/div result), buffered in a small FIFO and drained into idle WB slots.
- Also forwards FIFO-held results and raises a stall request when the buffer fills.

Parameters:
- DEPTH, 4, secondary FIFO entries (power of 2, ≥2)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  clock, all state updates on posedge
- resetn  in  1  asynchronous active-low reset
- wb_we  in  1  pipeline WB write enable
- wb_wa  in  AW  pipeline WB destination register
- wb_wd  in  DW  pipeline WB data
- sec_valid  in  1  secondary write request
- sec_ready  out  1  secondary request accepted this cycle
- sec_wa  in  AW  secondary destination
- sec_wd  in  DW  secondary data
- rf_we  out  1  to regfile we3
- rf_wa  out  AW  to regfile wa3
- rf_wd  out  DW  to regfile wd3
- fwd_ra1, fwd_ra2  in  AW  decode-stage source registers
- fwd_hit1, fwd_hit2  out  1  a queued write targets fwd_raN
- fwd_d1, fwd_d2  out  DW  data of youngest matching queued entry
- wb_stall_req  out  1  FIFO full; hazard unit must stall the pipeline
- fifo_count  out  clog2(DEPTH)+1  occupancy, debug

Behaviour:
- Reset (resetn=0, async):
  - FIFO empty, all entry valid bits 0, pointers 0.
  - Outputs: rf_we=0, sec_ready=1, wb_stall_req=0, fwd_hit*=0, fifo_count=0.
- Pipeline-active definition: wb_act = wb_we && wb_wa!=0. Writes to $0 are treated as idle at both inputs.
- Write port mux (combinational, zero latency):
  - wb_act: drive rf_* = wb_*.
  - else if FIFO head valid: drive rf_* = head entry, rf_we=1, pop at posedge.
  - else rf_we=0. rf_wa/rf_wd are don't-care but driven 0.
- Regfile samples on negedge, so rf_* must be stable from posedge to negedge. Outputs derive only from inputs and registered state; there are no negedge flops here.
- Secondary accept:
  - sec_ready = !full || pop_this_cycle.
  - Push at posedge when sec_valid && sec_ready && sec_wa!=0.
  - sec_valid with sec_wa==0 is acked (sec_ready=1) and discarded.
- Latency: a pushed entry is emitted no earlier than the cycle after push. There is no same-cycle bypass to rf_*.
- Simultaneous push and pop with FIFO full is allowed; count is unchanged.
- WAW squash: when wb_act and a queued valid entry has wa==wb_wa, that entry's valid bit clears at posedge. The pipeline write is younger by contract.
  - A squashed head is popped without asserting rf_we. Squashed entries never reach the regfile.
  - An entry pushed in the same cycle as a matching wb write is NOT squashed. That entry is younger.
- Forwarding: fwd_hitN=1 iff fwd_raN!=0 and some valid entry has wa==fwd_raN. fwd_dN is from the youngest such entry. An entry being pushed this cycle is not visible until the next cycle.
- wb_stall_req = full && !pop_possible, registered-free (combinational from count and wb_act).
- Pointer wrap: pointers are clog2(DEPTH)+1 bits; full/empty are decided by MSB compare.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - REG_AW=5, REG_DW=32, REG_ZERO=5'd0;
  - typedef wb_req_t {we, wa[4:0], wd[31:0]}, reused by the pipeline WB stage.
- One sub-module: wb_fifo.
  - Parameterized circular buffer with a per-entry valid bit and a squash-by-address input.
  - Exposes all entries for the forwarding compare.
- The top level holds the mux, the accept logic and the forwarding priority encoder.

Test Plan:
- Reset mid-drain: queue 3 entries, assert resetn=0 async mid-cycle -> rf_we=0 immediately, fifo_count=0, sec_ready=1; no further writes after release.
- Idle drain: sec write r5=0x1234 at cycle 0, wb idle -> cycle 1 rf_we=1, rf_wa=5, rf_wd=0x1234; cycle 2 rf_we=0, count=0.
- Priority/full: wb_act every cycle, push 4 entries -> count=4, wb_stall_req=1, sec_ready=0; drop wb_we -> entries drain in order, one per cycle.
- WAW squash: queue r7=0xAAAA, then wb writes r7=0xBBBB -> regfile r7 ends 0xBBBB; squashed entry popped with rf_we=0.
- Forwarding: queue r3=0x11 then r3=0x22, fwd_ra1=3 -> fwd_hit1=1, fwd_d1=0x22; fwd_ra2=0 -> fwd_hit2=0.
- $0 filter: sec_valid with sec_wa=0, wd=0xFFFF -> acked, count unchanged, rf_we never 1 for wa=0.
